// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: shared state encodings, BCD limit and BCD increment helper
package score_keeper_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i+:4] == 4'd9) r[4*i+:4] = 4'd0;
        else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/score_keeper_bcd_counter4.sv
// bcd_counter4: saturating 4-digit BCD incrementer, clear wins over increment
module bcd_counter4
  import score_keeper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);
  logic [15:0] q_q, q_d;

  // next count: clear, saturating increment, or hold
  always_comb q_d = clr ? 16'h0000 : (inc && q_q != BCD_MAX) ? bcd_inc(q_q) : q_q;

  // count register
  always_ff @(posedge clk) q_q <= rst ? 16'h0000 : q_d;

  assign q = q_q;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: game session FSM with BCD score, lives, miss tracking and countdown
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int TICK_DIV     = 100_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int LIVES        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        guess_correct,
  input  logic        guess_wrong,
  input  logic        mole_change,
  output logic [15:0] score_bcd,
  output logic [2:0]  lives_left,
  output logic [6:0]  secs_left,
  output logic        playing,
  output logic        game_over
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [6:0] SECS_INIT = 7'(GAME_SECONDS);

  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [6:0] secs_q, secs_d;
  logic [2:0] lives_q, lives_d;
  logic armed_q, armed_d;
  logic in_play, launch, hit, lose, wrap;

  assign in_play = state_q == ST_PLAY;
  assign launch  = start && !in_play;
  assign hit     = in_play && guess_correct;
  // a wrong guess loses a life only without a hit; a miss needs an armed mole and no guess at all
  assign lose    = in_play && ((guess_wrong && !guess_correct) ||
                               (mole_change && armed_q && !guess_correct && !guess_wrong));
  assign wrap    = in_play && tick_q == TICK_LAST;

  // next-state: session launch, countdown, lives and arming; OVER freezes everything
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    secs_d  = secs_q;
    lives_d = lives_q;
    armed_d = armed_q;
    if (launch) begin
      state_d = ST_PLAY;
      tick_d  = '0;
      secs_d  = SECS_INIT;
      lives_d = LIVES_INIT;
      armed_d = 1'b0;
    end else if (in_play) begin
      tick_d  = wrap ? '0 : tick_q + 1'b1;
      secs_d  = wrap ? secs_q - 7'd1 : secs_q;
      lives_d = lose ? lives_q - 3'd1 : lives_q;
      armed_d = mole_change || (armed_q && !guess_correct && !guess_wrong);
      if ((wrap && secs_q == 7'd1) || (lose && lives_q == 3'd1)) state_d = ST_OVER;
    end
  end

  // session state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      secs_q  <= SECS_INIT;
      lives_q <= LIVES_INIT;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      secs_q  <= secs_d;
      lives_q <= lives_d;
      armed_q <= armed_d;
    end
  end

  bcd_counter4 u_score (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (hit),
    .q   (score_bcd)
  );

  assign lives_left = lives_q;
  assign secs_left  = secs_q;
  assign playing    = state_q == ST_PLAY;
  assign game_over  = state_q == ST_OVER;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed checks of session flow, scoring, lives, countdown and saturation
module tb_score_keeper;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, gc = 1'b0, gw = 1'b0, mc = 1'b0;
  logic s_start = 1'b0, s_gc = 1'b0, zero = 1'b0;
  logic [15:0] score, s_score;
  logic [2:0] lives, s_lives;
  logic [6:0] secs, s_secs;
  logic playing, game_over, s_playing, s_game_over;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  score_keeper #(.TICK_DIV(4), .GAME_SECONDS(5), .LIVES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .guess_correct(gc), .guess_wrong(gw),
    .mole_change(mc), .score_bcd(score), .lives_left(lives), .secs_left(secs),
    .playing(playing), .game_over(game_over)
  );

  score_keeper #(.TICK_DIV(128), .GAME_SECONDS(99), .LIVES(3)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .guess_correct(s_gc), .guess_wrong(zero),
    .mole_change(zero), .score_bcd(s_score), .lives_left(s_lives), .secs_left(s_secs),
    .playing(s_playing), .game_over(s_game_over)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic hit();
    gc = 1'b1; step(); gc = 1'b0;
  endtask

  task automatic wait_over();
    for (int i = 0; i < 40 && !game_over; i++) step();
    chk("wait_over", game_over, 1);
  endtask

  initial begin
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_score", score, 16'h0000);
    chk("rst_lives", lives, 3);
    chk("rst_secs", secs, 5);
    chk("rst_playing", playing, 0);
    chk("rst_over", game_over, 0);

    repeat (3) hit();
    chk("idle_score", score, 16'h0000);
    chk("idle_playing", playing, 0);

    pulse_start();
    chk("start_playing", playing, 1);
    chk("start_secs", secs, 5);
    repeat (12) hit();
    chk("score_12", score, 16'h0012);
    chk("lives_12", lives, 3);
    pulse_start();
    chk("start_in_play_ignored", score, 16'h0012);
    wait_over();
    chk("over_score_hold", score, 16'h0012);
    chk("over_secs", secs, 0);
    chk("over_playing", playing, 0);
    hit();
    chk("over_hit_ignored", score, 16'h0012);

    pulse_start();
    chk("restart_score", score, 16'h0000);
    gc = 1'b1; gw = 1'b1; step(); gc = 1'b0; gw = 1'b0;
    chk("both_score", score, 16'h0001);
    chk("both_lives", lives, 3);
    wait_over();

    pulse_start();
    mc = 1'b1; step(); mc = 1'b0;
    chk("first_mole", lives, 3);
    mc = 1'b1; step(); mc = 1'b0;
    chk("miss_1", lives, 2);
    mc = 1'b1; step(); mc = 1'b0;
    chk("miss_2", lives, 1);
    gw = 1'b1; step(); gw = 1'b0;
    chk("last_life", lives, 0);
    chk("last_life_over", game_over, 1);
    chk("last_life_playing", playing, 0);
    pulse_start();
    chk("replay_lives", lives, 3);
    chk("replay_score", score, 16'h0000);
    chk("replay_playing", playing, 1);
    mc = 1'b1; step(); mc = 1'b0;
    mc = 1'b1; gc = 1'b1; step(); mc = 1'b0; gc = 1'b0;
    chk("mole_hit_score", score, 16'h0001);
    chk("mole_hit_lives", lives, 3);
    mc = 1'b1; step(); mc = 1'b0;
    chk("armed_after_hit", lives, 2);
    gw = 1'b1; step(); gw = 1'b0;
    chk("wrong_life", lives, 1);
    mc = 1'b1; step(); mc = 1'b0;
    chk("wrong_disarms", lives, 1);
    wait_over();

    pulse_start();
    chk("cd_secs_5", secs, 5);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) step();
      chk("cd_before_wrap", secs, 7'(6 - k));
      step();
      chk("cd_secs", secs, 7'(5 - k));
    end
    chk("cd_over", game_over, 1);
    repeat (3) step();
    chk("cd_hold_secs", secs, 0);
    chk("cd_hold_lives", lives, 3);
    chk("cd_hold_over", game_over, 1);

    pulse_start();
    repeat (7) hit();
    chk("pre_rst_score", score, 16'h0007);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_score", score, 16'h0000);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_secs", secs, 5);
    chk("mid_rst_playing", playing, 0);
    chk("mid_rst_over", game_over, 0);

    s_start = 1'b1; step(); s_start = 1'b0;
    s_gc = 1'b1;
    repeat (9998) step();
    chk("sat_9998", s_score, 16'h9998);
    step();
    chk("sat_9999", s_score, 16'h9999);
    step();
    chk("sat_hold", s_score, 16'h9999);
    chk("sat_playing", s_playing, 1);
    s_gc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
